rv_instr_encoder: RTL and testbench

//  Streaming RV32I instruction encoder: the inverse of the single-cycle control/ALU decode path.

---
 rtl/riscv_enc_pkg.sv | 46 ++++
 rtl/rv_instr_pack.sv | 67 ++++++
 rtl/rv_instr_encoder.sv | 93 +++++++++
 tb/tb_rv_instr_encoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoder definitions: opcodes, op kinds, ALU codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_enc_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        K_LW    = 3'd0,
        K_SW    = 3'd1,
        K_RTYPE = 3'd2,
        K_BEQ   = 3'd3,
        K_ITYPE = 3'd4,
        K_JAL   = 3'd5
    } op_kind_t;

    // ALU codes as produced by the core's decoder
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic logic [2:0] alu_funct3(input logic [2:0] alu);
        logic [2:0] f3;
        case (alu)
            ALU_SLT: f3 = 3'b010;
            ALU_OR:  f3 = 3'b110;
            ALU_AND: f3 = 3'b111;
            default: f3 = 3'b000;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Packs decoded op fields into one RV32I word and flags unencodable ops.
// Latency: combinational.
// Backpressure: none.
module rv_instr_pack
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  alu_ctl,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic signed [31:0] imm_s;
    logic               in12;
    logic               in13;
    logic               in21;
    logic               alu_ok;
    logic [2:0]         f3;
    logic [6:0]         f7;

    assign imm_s  = $signed(imm);
    assign in12   = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
    assign in13   = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094);
    assign in21   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);
    assign alu_ok = (alu_ctl == ALU_ADD) || (alu_ctl == ALU_SUB) || (alu_ctl == ALU_AND) ||
                    (alu_ctl == ALU_OR)  || (alu_ctl == ALU_SLT);
    assign f3     = alu_funct3(alu_ctl);
    assign f7     = (alu_ctl == ALU_SUB) ? 7'b0100000 : 7'b0000000;

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            K_LW: begin
                word    = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
                illegal = !in12;
            end
            K_SW: begin
                word    = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
                illegal = !in12;
            end
            K_RTYPE: begin
                word    = {f7, rs2, rs1, f3, rd, OPC_RTYPE};
                illegal = !alu_ok;
            end
            K_BEQ: begin
                word    = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
                illegal = !in13 || imm[0];
            end
            K_ITYPE: begin
                // there is no subi: negative immediates cover it
                word    = {imm[11:0], rs1, f3, rd, OPC_ITYPE};
                illegal = !alu_ok || (alu_ctl == ALU_SUB) || !in12;
            end
            K_JAL: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
                illegal = !in21 || imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// Streams decoded ops into imem as packed RV32I words at consecutive addresses.
// Latency: 1 cycle from accept to imem write; one op per cycle.
// Backpressure: op_ready low outside RUN and once DEPTH words are written.
module rv_instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic          op_last,
    input  logic [2:0]    op_kind,
    input  logic [2:0]    alu_ctl,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [31:0]   imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count
);

    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    state_t      state;
    logic        accept;
    logic [31:0] word;
    logic        illegal;

    rv_instr_pack u_pack (
        .kind    (op_kind),
        .alu_ctl (alu_ctl),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .imm     (imm),
        .word    (word),
        .illegal (illegal)
    );

    assign op_ready = (state == ST_RUN) && (count < CNT_FULL);
    assign accept   = op_valid && op_ready;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            count      <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        // count advances with the write so op_ready sees it next cycle
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= count[AW-1:0];
                            imem_wdata <= word;
                            count      <= count + CNT_ONE;
                        end
                        if (op_last) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed-vector bench for rv_instr_encoder with hand-computed instruction words.
module tb_rv_instr_encoder;
    import riscv_enc_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, op_valid, op_ready, op_last;
    logic [2:0]  op_kind, alu_ctl;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        imem_we, busy, done, err;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;

    rv_instr_encoder #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op_valid(op_valid), .op_ready(op_ready),
        .op_last(op_last), .op_kind(op_kind), .alu_ctl(alu_ctl), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int          wq_addr[$];
    int          wq_cyc[$];
    logic [31:0] wq_dat[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wq_addr.push_back(int'(imem_addr));
            wq_dat.push_back(imem_wdata);
            wq_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_dat.delete();
        wq_cyc.delete();
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic put(input logic [2:0] k, input logic [2:0] a, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                       input logic last);
        int n;
        @(negedge clk);
        op_kind = k; alu_ctl = a; rd = d; rs1 = s1; rs2 = s2; imm = im; op_last = last;
        op_valid = 1'b1;
        n = 0;
        while (op_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (op_ready !== 1'b1) check("put_ready_timeout", {31'b0, op_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic end_ops();
        @(negedge clk);
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cnt);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_count"}, {25'b0, count}, exp_cnt);
        @(negedge clk);
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, wq_dat.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wq_dat.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wq_addr[i], i);
            check($sformatf("%s_dat%0d", tag, i), wq_dat[i], exp_q[i]);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_valid = 1'b0; op_last = 1'b0;
        op_kind = '0; alu_ctl = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(negedge clk);
        check("rst_we", {31'b0, imem_we}, 0);
        check("rst_ready", {31'b0, op_ready}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_addr", {26'b0, imem_addr}, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", {25'b0, count}, 0);
        reset = 1'b0;

        // 1: single ITYPE addi x1,x0,5
        clear_log();
        pulse_start();
        check("t1_ready", {31'b0, op_ready}, 1);
        check("t1_busy", {31'b0, busy}, 1);
        put(K_ITYPE, ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        end_ops();
        check("t1_we", {31'b0, imem_we}, 1);
        check("t1_addr", {26'b0, imem_addr}, 0);
        check("t1_wdata", imem_wdata, 32'h00500093);
        check("t1_done_early", {31'b0, done}, 0);
        check("t1_count_n1", {25'b0, count}, 1);
        @(negedge clk);
        check("t1_done_pulse", {31'b0, done}, 1);
        check("t1_we_off", {31'b0, imem_we}, 0);
        wait_done("t1", 1);

        // 2: add/sub back-to-back, no bubble
        clear_log();
        pulse_start();
        put(K_RTYPE, ALU_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        put(K_RTYPE, ALU_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        end_ops();
        wait_done("t2", 2);
        exp_q = '{32'h002081B3, 32'h402081B3};
        check_writes("t2");
        if (wq_cyc.size() == 2) check("t2_nobubble", wq_cyc[1] - wq_cyc[0], 1);

        // 3+4: loads, stores, branch, jump
        clear_log();
        pulse_start();
        put(K_LW,  ALU_ADD, 5'd2, 5'd1, 5'd0, 32'd8, 1'b0);
        put(K_SW,  ALU_ADD, 5'd0, 5'd1, 5'd2, 32'd4, 1'b0);
        put(K_BEQ, ALU_ADD, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0);
        put(K_JAL, ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1);
        end_ops();
        wait_done("t34", 4);
        exp_q = '{32'h0080A103, 32'h0020A223, 32'hFE208CE3, 32'h010000EF};
        check_writes("t34");

        // remaining funct3 codes and immediate range edges
        clear_log();
        pulse_start();
        put(K_RTYPE, ALU_OR,  5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        put(K_RTYPE, ALU_AND, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        put(K_RTYPE, ALU_SLT, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        put(K_ITYPE, ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd2047, 1'b0);
        put(K_ITYPE, ALU_ADD, 5'd1, 5'd0, 5'd0, -32'sd2048, 1'b0);
        put(K_BEQ,   ALU_ADD, 5'd0, 5'd0, 5'd0, 32'd4094, 1'b0);
        put(K_JAL,   ALU_ADD, 5'd0, 5'd0, 5'd0, -32'sd1048576, 1'b1);
        end_ops();
        wait_done("tb", 7);
        check("tb_err", {31'b0, err}, 0);
        exp_q = '{32'h0020E1B3, 32'h0020F1B3, 32'h0020A1B3, 32'h7FF00093,
                  32'h80000093, 32'h7E000FE3, 32'h8000006F};
        check_writes("tb");

        // 5: rejected ops, last one still ends the program
        clear_log();
        pulse_start();
        put(K_ITYPE, ALU_SUB, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
        put(K_ITYPE, ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        put(3'd6,    ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
        put(K_RTYPE, 3'b100,  5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
        put(K_BEQ,   ALU_ADD, 5'd0, 5'd1, 5'd2, 32'd3, 1'b1);
        end_ops();
        wait_done("t5", 0);
        check("t5_err", {31'b0, err}, 1);
        check("t5_nwr", wq_dat.size(), 0);
        pulse_start();
        check("t5_err_clr", {31'b0, err}, 0);
        put(K_ITYPE, ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        end_ops();
        wait_done("t5b", 1);

        // 6: fill to DEPTH with op_valid held high
        clear_log();
        pulse_start();
        for (int i = 0; i < 64; i++) put(K_ITYPE, ALU_ADD, 5'd1, 5'd0, 5'd0, i, 1'b0);
        @(negedge clk);
        check("t6_ready_full", {31'b0, op_ready}, 0);
        check("t6_count", {25'b0, count}, 64);
        check("t6_last_addr", {26'b0, imem_addr}, 63);
        check("t6_last_dat", imem_wdata, 32'h03F00093);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("t6_hold_count", {25'b0, count}, 64);
        check("t6_hold_busy", {31'b0, busy}, 1);
        check("t6_hold_we", {31'b0, imem_we}, 0);
        check("t6_nwr", wq_dat.size(), 64);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        op_valid = 1'b0;
        check("t6r_busy", {31'b0, busy}, 0);
        check("t6r_count", {25'b0, count}, 0);
        check("t6r_addr", {26'b0, imem_addr}, 0);
        check("t6r_wdata", imem_wdata, 0);
        check("t6r_ready", {31'b0, op_ready}, 0);

        // reset coinciding with an accept drops that write
        pulse_start();
        @(negedge clk);
        op_kind = K_ITYPE; alu_ctl = ALU_ADD; rd = 5'd1; rs1 = 5'd0; imm = 32'd9;
        op_last = 1'b1; op_valid = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; op_valid = 1'b0; op_last = 1'b0;
        check("t6p_we", {31'b0, imem_we}, 0);
        check("t6p_count", {25'b0, count}, 0);
        check("t6p_busy", {31'b0, busy}, 0);
        check("t6p_err", {31'b0, err}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
